// File: rtl/exception_ctrl_if.sv
// MEM-stage exception controller bus: pipeline/CP0 inputs and commit/redirect outputs.
interface exception_ctrl_if #(
  parameter int unsigned HW_INT = 6
) ();
  logic              validM;
  logic              stallM;
  logic [31:0]       pcM;
  logic              in_dslotM;
  logic [7:0]        exc_vecM;
  logic [31:0]       aluoutM;
  logic [31:0]       cp0_status;
  logic [31:0]       cp0_cause;
  logic [31:0]       cp0_epc;
  logic [HW_INT-1:0] hw_int;

  logic              exc_valid;
  logic              is_eret;
  logic [4:0]        exc_code;
  logic              exc_bd;
  logic [31:0]       epc_o;
  logic [31:0]       bad_addr;
  logic              bad_addr_we;
  logic              flush;
  logic [31:0]       newpc;
  logic              busy;

  modport master (
    output validM, stallM, pcM, in_dslotM, exc_vecM, aluoutM,
           cp0_status, cp0_cause, cp0_epc, hw_int,
    input  exc_valid, is_eret, exc_code, exc_bd, epc_o, bad_addr,
           bad_addr_we, flush, newpc, busy
  );

  modport slave (
    input  validM, stallM, pcM, in_dslotM, exc_vecM, aluoutM,
           cp0_status, cp0_cause, cp0_epc, hw_int,
    output exc_valid, is_eret, exc_code, exc_bd, epc_o, bad_addr,
           bad_addr_we, flush, newpc, busy
  );
endinterface

// File: rtl/exception_ctrl.sv
// MEM-stage exception/interrupt controller: prioritises sources, commits to CP0,
// and holds a pipeline flush with PC redirect for FLUSH_CYCLES cycles.
module exception_ctrl #(
  parameter int unsigned HW_INT       = 6,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380
) (
  input  logic             clk,
  input  logic             rst,
  exception_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HW_INT-1:0] sync1_q, sync2_q;

  logic [7:0]  ip;
  logic        int_req;
  logic        adel_fetch;
  logic        any_src;
  logic        commit;
  logic        take_eret;
  logic [4:0]  code_c;
  logic [31:0] bad_c;
  logic        bad_we_c;
  logic [31:0] epc_c;
  logic        unused_bits;

  assign unused_bits = ^{bus.cp0_status[31:16], bus.cp0_status[7:2],
                         bus.cp0_cause[31:10], bus.cp0_cause[7:0]};

  // Two-flop synchroniser for the asynchronous interrupt lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.hw_int;
      sync2_q <= sync1_q;
    end
  end

  // Source prioritisation and commit decision.
  always_comb begin
    ip         = {6'(sync2_q), bus.cp0_cause[9:8]};
    int_req    = (|(ip & bus.cp0_status[15:8])) & bus.cp0_status[0] & ~bus.cp0_status[1];
    adel_fetch = (|bus.pcM[1:0]) | bus.exc_vecM[7];
    any_src    = int_req | adel_fetch | (|bus.exc_vecM);
    commit     = (state_q == IDLE) & bus.validM & ~bus.stallM & any_src;
    take_eret  = 1'b0;
    code_c     = 5'h00;
    bad_c      = 32'h0;
    bad_we_c   = 1'b0;
    epc_c      = bus.in_dslotM ? (bus.pcM - 32'd4) : bus.pcM;
    if (int_req) begin
      code_c = 5'h00;
    end else if (adel_fetch) begin
      code_c   = 5'h04;
      bad_c    = bus.pcM;
      bad_we_c = 1'b1;
    end else if (bus.exc_vecM[3]) begin
      code_c = 5'h0a;
    end else if (bus.exc_vecM[4]) begin
      code_c = 5'h0c;
    end else if (bus.exc_vecM[1]) begin
      code_c = 5'h08;
    end else if (bus.exc_vecM[2]) begin
      code_c = 5'h09;
    end else if (bus.exc_vecM[5]) begin
      code_c   = 5'h04;
      bad_c    = bus.aluoutM;
      bad_we_c = 1'b1;
    end else if (bus.exc_vecM[6]) begin
      code_c   = 5'h05;
      bad_c    = bus.aluoutM;
      bad_we_c = 1'b1;
    end else begin
      take_eret = bus.exc_vecM[0];
    end
  end

  // Flush FSM next-state: stay in FLUSH until the hold counter expires.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (commit) begin
          state_d = FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register and registered commit/redirect outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      bus.exc_valid   <= 1'b0;
      bus.is_eret     <= 1'b0;
      bus.exc_code    <= 5'h0;
      bus.exc_bd      <= 1'b0;
      bus.epc_o       <= 32'h0;
      bus.bad_addr    <= 32'h0;
      bus.bad_addr_we <= 1'b0;
      bus.flush       <= 1'b0;
      bus.newpc       <= 32'h0;
      bus.busy        <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bus.exc_valid   <= commit & ~take_eret;
      bus.is_eret     <= commit & take_eret;
      bus.bad_addr_we <= commit & ~take_eret & bad_we_c;
      bus.flush       <= (state_d == FLUSH);
      bus.busy        <= (state_d == FLUSH);
      if (commit & ~take_eret) begin
        bus.exc_code <= code_c;
        bus.exc_bd   <= bus.in_dslotM;
        bus.epc_o    <= epc_c;
        bus.bad_addr <= bad_c;
      end
      if (commit) begin
        bus.newpc <= take_eret ? bus.cp0_epc : EXC_VECTOR;
      end
    end
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl with a scoreboard of expected commit pulses.
module tb_exception_ctrl;

  localparam int unsigned HW_INT       = 4;
  localparam int unsigned FLUSH_CYCLES = 3;
  localparam logic [31:0] EXC_VECTOR   = 32'hBFC00380;

  typedef struct packed {
    logic        v;
    logic        er;
    logic [4:0]  code;
    logic [31:0] epc;
    logic [31:0] bad;
    logic        we;
    logic        bd;
    logic [31:0] npc;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sbq[$];
  exp_t e;

  exception_ctrl_if #(.HW_INT(HW_INT)) ifc ();

  exception_ctrl #(
    .HW_INT(HW_INT),
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .EXC_VECTOR(EXC_VECTOR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference priority model, written straight from the source table.
  function automatic exp_t predict(input logic int_req, input logic [31:0] pc,
                                   input logic dslot, input logic [7:0] vec,
                                   input logic [31:0] alu, input logic [31:0] epc_in);
    exp_t r;
    r      = '0;
    r.v    = 1'b1;
    r.npc  = EXC_VECTOR;
    r.bd   = dslot;
    r.epc  = dslot ? pc - 32'd4 : pc;
    if (int_req)                          r.code = 5'h00;
    else if (pc[1:0] != 2'b00 || vec[7]) begin r.code = 5'h04; r.bad = pc;  r.we = 1'b1; end
    else if (vec[3])                      r.code = 5'h0a;
    else if (vec[4])                      r.code = 5'h0c;
    else if (vec[1])                      r.code = 5'h08;
    else if (vec[2])                      r.code = 5'h09;
    else if (vec[5]) begin r.code = 5'h04; r.bad = alu; r.we = 1'b1; end
    else if (vec[6]) begin r.code = 5'h05; r.bad = alu; r.we = 1'b1; end
    else begin r.v = 1'b0; r.er = 1'b1; r.npc = epc_in; end
    return r;
  endfunction

  // Advance one cycle, sample after the edge, and match any commit pulse to the scoreboard.
  task automatic tick();
    exp_t x;
    @(posedge clk);
    #1;
    if (ifc.exc_valid === 1'b1 || ifc.is_eret === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_pulse", {30'h0, ifc.exc_valid, ifc.is_eret}, 32'h0);
      end else begin
        x = sbq.pop_front();
        chk("exc_valid", {31'h0, ifc.exc_valid}, {31'h0, x.v});
        chk("is_eret",   {31'h0, ifc.is_eret},   {31'h0, x.er});
        chk("newpc",     ifc.newpc,              x.npc);
        if (x.v) begin
          chk("exc_code",    {27'h0, ifc.exc_code},   {27'h0, x.code});
          chk("epc_o",       ifc.epc_o,               x.epc);
          chk("bad_addr",    ifc.bad_addr,            x.bad);
          chk("bad_addr_we", {31'h0, ifc.bad_addr_we}, {31'h0, x.we});
          chk("exc_bd",      {31'h0, ifc.exc_bd},     {31'h0, x.bd});
        end
      end
    end
  endtask

  task automatic idle_inputs();
    ifc.validM    = 1'b0;
    ifc.stallM    = 1'b0;
    ifc.pcM       = 32'h0;
    ifc.in_dslotM = 1'b0;
    ifc.exc_vecM  = 8'h0;
    ifc.aluoutM   = 32'h0;
  endtask

  task automatic drive(input logic [31:0] pc, input logic dslot, input logic [7:0] vec,
                       input logic [31:0] alu);
    ifc.validM    = 1'b1;
    ifc.stallM    = 1'b0;
    ifc.pcM       = pc;
    ifc.in_dslotM = dslot;
    ifc.exc_vecM  = vec;
    ifc.aluoutM   = alu;
  endtask

  // Expect a commit on the next edge, then a flush of FLUSH_CYCLES with inputs still asserted.
  task automatic run_commit(input exp_t x, input string tag);
    sbq.push_back(x);
    tick();
    chk({tag, "_drain"}, sbq.size(), 0);
    chk({tag, "_flush"}, {31'h0, ifc.flush}, 32'h1);
    chk({tag, "_busy"},  {31'h0, ifc.busy},  32'h1);
    for (int i = 1; i < int'(FLUSH_CYCLES); i++) begin
      tick();
      chk({tag, "_flush_hold"}, {31'h0, ifc.flush},     32'h1);
      chk({tag, "_pulse_once"}, {31'h0, ifc.exc_valid | ifc.is_eret}, 32'h0);
    end
    tick();
    chk({tag, "_flush_end"}, {31'h0, ifc.flush}, 32'h0);
    chk({tag, "_busy_end"},  {31'h0, ifc.busy},  32'h0);
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    idle_inputs();
    ifc.cp0_status = 32'h0;
    ifc.cp0_cause  = 32'h0;
    ifc.cp0_epc    = 32'h0;
    ifc.hw_int     = '0;
    tick();
    tick();
    chk("rst_exc_valid", {31'h0, ifc.exc_valid}, 32'h0);
    chk("rst_flush",     {31'h0, ifc.flush},     32'h0);
    chk("rst_busy",      {31'h0, ifc.busy},      32'h0);
    chk("rst_epc",       ifc.epc_o,              32'h0);
    chk("rst_newpc",     ifc.newpc,              32'h0);
    rst = 1'b0;
    tick();

    // Overflow
    drive(32'h80, 1'b0, 8'h10, 32'h0);
    run_commit(predict(1'b0, 32'h80, 1'b0, 8'h10, 32'h0, 32'h0), "ov");
    // Misaligned fetch in a delay slot
    drive(32'h1006, 1'b1, 8'h00, 32'h0);
    run_commit(predict(1'b0, 32'h1006, 1'b1, 8'h00, 32'h0, 32'h0), "dslot_adel");
    // Priority: sys beats bp/adel/ades; ov beats eret
    drive(32'h200, 1'b0, 8'h62, 32'h5);
    run_commit(predict(1'b0, 32'h200, 1'b0, 8'h62, 32'h5, 32'h0), "prio_sys");
    drive(32'h204, 1'b0, 8'h11, 32'h0);
    run_commit(predict(1'b0, 32'h204, 1'b0, 8'h11, 32'h0, 32'h0), "prio_ov_eret");
    // Remaining sources and EPC wrap
    drive(32'h300, 1'b0, 8'h20, 32'h3001);
    run_commit(predict(1'b0, 32'h300, 1'b0, 8'h20, 32'h3001, 32'h0), "adel_data");
    drive(32'h304, 1'b0, 8'h40, 32'h4002);
    run_commit(predict(1'b0, 32'h304, 1'b0, 8'h40, 32'h4002, 32'h0), "ades");
    drive(32'h308, 1'b0, 8'h1c, 32'h0);
    run_commit(predict(1'b0, 32'h308, 1'b0, 8'h1c, 32'h0, 32'h0), "ri");
    drive(32'h30c, 1'b0, 8'h04, 32'h0);
    run_commit(predict(1'b0, 32'h30c, 1'b0, 8'h04, 32'h0, 32'h0), "bp");
    drive(32'h0, 1'b1, 8'h80, 32'h0);
    run_commit(predict(1'b0, 32'h0, 1'b1, 8'h80, 32'h0, 32'h0), "adel_wrap");

    // Stalled and bubble instructions never commit
    drive(32'h400, 1'b0, 8'h10, 32'h0);
    ifc.stallM = 1'b1;
    tick();
    ifc.stallM = 1'b0;
    ifc.validM = 1'b0;
    tick();
    chk("stall_bubble_busy", {31'h0, ifc.busy}, 32'h0);
    idle_inputs();

    // eret
    ifc.cp0_epc = 32'h2000;
    drive(32'h500, 1'b0, 8'h01, 32'h0);
    run_commit(predict(1'b0, 32'h500, 1'b0, 8'h01, 32'h0, 32'h2000), "eret");

    // Interrupt through synchroniser with two stalled cycles
    ifc.cp0_status = 32'h0000_0401;
    drive(32'h600, 1'b0, 8'h00, 32'h0);
    ifc.stallM = 1'b1;
    ifc.hw_int = HW_INT'(1);
    tick();
    tick();
    chk("int_not_yet", {31'h0, ifc.exc_valid}, 32'h0);
    ifc.stallM = 1'b0;
    run_commit(predict(1'b1, 32'h600, 1'b0, 8'h00, 32'h0, 32'h0), "int");
    ifc.hw_int = '0;
    for (int i = 0; i < 4; i++) tick();
    // Interrupt masked by EXL
    ifc.cp0_status = 32'h0000_0403;
    ifc.hw_int = HW_INT'(1);
    drive(32'h700, 1'b0, 8'h00, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    chk("exl_no_commit", {31'h0, ifc.busy}, 32'h0);
    idle_inputs();
    ifc.hw_int = '0;
    ifc.cp0_status = 32'h0;
    for (int i = 0; i < 3; i++) tick();

    // Reset in the second flush cycle
    drive(32'h800, 1'b0, 8'h10, 32'h0);
    sbq.push_back(predict(1'b0, 32'h800, 1'b0, 8'h10, 32'h0, 32'h0));
    tick();
    idle_inputs();
    tick();
    chk("mid_flush", {31'h0, ifc.flush}, 32'h1);
    rst = 1'b1;
    tick();
    chk("rst_mid_flush",  {31'h0, ifc.flush},    32'h0);
    chk("rst_mid_busy",   {31'h0, ifc.busy},     32'h0);
    chk("rst_mid_code",   {27'h0, ifc.exc_code}, 32'h0);
    chk("rst_mid_epc",    ifc.epc_o,             32'h0);
    chk("rst_mid_newpc",  ifc.newpc,             32'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_busy", {31'h0, ifc.busy}, 32'h0);
    chk("sb_final", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
